// File: rtl/minrv32_dmem_responder.sv
// Data-port responder for minrv32: word RAM plus a console TX FIFO, with byte-lane
// steering from right-justified core data, wait-state insertion and fault reporting.
module minrv32_dmem_responder #(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic [3:0]  mem_rmask,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [32:0] RAM_END = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] ram [MEM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [31:0]   addr_rel;
  logic [IW-1:0] word_idx;
  logic [1:0]    off;
  logic [3:0]    size;
  logic [7:0]    lanes_wide;
  logic [3:0]    lane_en;
  logic [31:0]   wr_data, load_mask, ram_shifted, status, load_val;
  logic [3:0]    cnt4;
  logic is_store, in_ram, is_con, misaligned, fault_req;
  logic con_store, fifo_full, pop, push, at_end, stall, ram_we;
  logic unused_bits;

  assign addr_rel    = mem_addr - BASE_ADDR;
  assign word_idx    = addr_rel[IW+1:2];
  assign off         = mem_addr[1:0];
  assign unused_bits = ^{mem_instr, addr_rel[31:IW+2], addr_rel[1:0]};

  // A request with both masks set is a store; the size comes from whichever mask applies.
  assign is_store   = |mem_wstrb;
  assign size       = is_store ? mem_wstrb : mem_rmask;
  assign misaligned = ((size == 4'b0011) && off[0]) || ((size == 4'b1111) && (off != 2'd0));
  assign is_con     = (mem_addr[31:2] == CONSOLE_ADDR[31:2]);
  assign in_ram     = !is_con && ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, mem_addr} < RAM_END);
  assign fault_req  = misaligned || !(in_ram || is_con);

  assign lanes_wide = {4'b0, mem_wstrb} << off;
  assign lane_en    = lanes_wide[3:0];
  assign wr_data    = mem_wdata << {off, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lmask
      assign load_mask[8*gi +: 8] = {8{mem_rmask[gi]}};
    end
  endgenerate

  assign ram_shifted = ram[word_idx] >> {off, 3'b000};
  assign cnt4        = 4'(count_q);
  assign status      = {24'b0, 3'b0, fifo_full, cnt4};
  assign load_val    = is_con ? status : (ram_shifted & load_mask);

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && console_ready;
  assign con_store = is_con && is_store && !fault_req;
  // A full FIFO holds off a console store unless the head leaves in the same cycle.
  assign stall     = con_store && fifo_full && !pop;
  assign at_end    = mem_valid && (((state_q == ST_IDLE) && (WAIT_STATES == 0)) ||
                                   ((state_q == ST_WAIT) && (cnt_q == 4'd0)));

  assign mem_ready = at_end && !stall && !reset;
  assign fault     = mem_ready && fault_req;
  assign mem_rdata = (mem_ready && !fault_req && !is_store) ? load_val : 32'd0;
  assign push      = mem_ready && con_store;
  assign ram_we    = mem_ready && is_store && in_ram && !fault_req;

  assign console_valid = (count_q != '0);
  assign console_data  = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && (WAIT_STATES != 0)) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      ST_WAIT: begin
        if (!mem_valid) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) ram[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (push) fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
  end
endmodule

// File: tb/tb_minrv32_dmem_responder.sv
// Directed bench: instance u0 runs with no wait states, u3 with three wait states.
module tb_minrv32_dmem_responder;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  logic        a_valid = 0, a_instr = 0, a_ready, a_fault, a_cvalid, a_cready = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
  logic [3:0]  a_wstrb = 0, a_rmask = 0;
  logic [7:0]  a_cdata;
  logic        b_valid = 0, b_instr = 0, b_ready, b_fault, b_cvalid, b_cready = 1;
  logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;
  logic [3:0]  b_wstrb = 0, b_rmask = 0;
  logic [7:0]  b_cdata;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] con_q[$];

  minrv32_dmem_responder #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .mem_valid(a_valid), .mem_instr(a_instr), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_rmask(a_rmask), .mem_ready(a_ready),
    .mem_rdata(a_rdata), .fault(a_fault), .console_valid(a_cvalid), .console_data(a_cdata),
    .console_ready(a_cready));

  minrv32_dmem_responder #(.WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .mem_valid(b_valid), .mem_instr(b_instr), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_rmask(b_rmask), .mem_ready(b_ready),
    .mem_rdata(b_rdata), .fault(b_fault), .console_valid(b_cvalid), .console_data(b_cdata),
    .console_ready(b_cready));

  always @(negedge clk) if (!reset && a_cvalid && a_cready) con_q.push_back(a_cdata);

  // Called at posedge+1; returns at posedge+1 with valid dropped. lat = -1 on timeout.
  task automatic xact(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [3:0] rmask,
                      output logic rdy, output logic [31:0] rd, output logic flt, output int lat);
    rdy = 0; rd = 0; flt = 0; lat = -1;
    if (!sel) begin a_valid = 1; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb; a_rmask = rmask; end
    else      begin b_valid = 1; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb; b_rmask = rmask; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel ? b_ready : a_ready) begin
        rdy = 1; rd = sel ? b_rdata : a_rdata; flt = sel ? b_fault : a_fault; lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    if (!sel) a_valid = 0; else b_valid = 0;
    $display("xact u%0d addr=%h wdata=%h wstrb=%b rmask=%b -> ready=%0d lat=%0d rdata=%h fault=%0d",
             sel ? 3 : 0, addr, wdata, wstrb, rmask, rdy, lat, rd, flt);
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    vectors++; if ({a_ready, a_fault, a_cvalid, b_ready} !== 4'b0) begin miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {a_ready, a_fault, a_cvalid, b_ready}); end
    vectors++; if (a_rdata !== 32'd0) begin miscompares++;
      $display("FAIL reset_rdata: got %h expected 00000000", a_rdata); end
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    vectors++; if ({a_ready, a_fault, a_cvalid, b_ready, b_fault} !== 5'b0) begin miscompares++;
      $display("FAIL post_reset_flags: got %b expected 00000", {a_ready, a_fault, a_cvalid, b_ready, b_fault}); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic r, f; logic [31:0] d; int l;
    xact(0, 32'h8, 32'hDEADBEEF, 4'b1111, 4'b0000, r, d, f, l);
    vectors++; if (l !== 0 || f !== 1'b0) begin miscompares++;
      $display("FAIL sw_ws0: got lat=%0d fault=%0d expected lat=0 fault=0", l, f); end
    xact(0, 32'h8, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (l !== 0 || f !== 1'b0 || d !== 32'hDEADBEEF) begin miscompares++;
      $display("FAIL lw_ws0: got lat=%0d fault=%0d rdata=%h expected 0 0 deadbeef", l, f, d); end
  endtask

  task automatic test_byte_lanes();
    logic r, f; logic [31:0] d; int l;
    xact(0, 32'hA, 32'h000000AA, 4'b0001, 4'b0000, r, d, f, l);
    xact(0, 32'h8, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (d !== 32'hDEAABEEF) begin miscompares++;
      $display("FAIL sb_lane2: got %h expected deaabeef", d); end
    xact(0, 32'hA, 32'h0, 4'b0000, 4'b0011, r, d, f, l);
    vectors++; if (d !== 32'h0000DEAA || f !== 1'b0) begin miscompares++;
      $display("FAIL lh_off2: got %h fault=%0d expected 0000deaa fault=0", d, f); end
    xact(0, 32'h9, 32'h0, 4'b0000, 4'b0001, r, d, f, l);
    vectors++; if (d !== 32'h000000BE) begin miscompares++;
      $display("FAIL lb_off1: got %h expected 000000be", d); end
    xact(0, 32'h8, 32'hFFFF1234, 4'b0011, 4'b0000, r, d, f, l);
    xact(0, 32'h8, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (d !== 32'hDEAA1234) begin miscompares++;
      $display("FAIL sh_off0: got %h expected deaa1234", d); end
  endtask

  task automatic test_wait_states();
    logic r, f; logic [31:0] d; int l;
    xact(1, 32'h8, 32'h11223344, 4'b1111, 4'b0000, r, d, f, l);
    vectors++; if (l !== 3) begin miscompares++;
      $display("FAIL sw_ws3_lat: got %0d expected 3", l); end
    xact(1, 32'h8, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (l !== 3 || d !== 32'h11223344) begin miscompares++;
      $display("FAIL lw_ws3: got lat=%0d rdata=%h expected 3 11223344", l, d); end
    @(negedge clk);
    vectors++; if (b_ready !== 1'b0) begin miscompares++;
      $display("FAIL ready_pulse: got %0d expected 0", b_ready); end
    @(posedge clk); #1;
    xact(1, 32'h9, 32'h0000FFFF, 4'b0011, 4'b0000, r, d, f, l);
    vectors++; if (l !== 3 || f !== 1'b1) begin miscompares++;
      $display("FAIL sh_misaligned: got lat=%0d fault=%0d expected 3 1", l, f); end
    xact(1, 32'h8, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (d !== 32'h11223344) begin miscompares++;
      $display("FAIL mem_unchanged: got %h expected 11223344", d); end
  endtask

  task automatic test_unmapped();
    logic r, f; logic [31:0] d; int l;
    xact(0, 32'h1000, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (l !== 0 || f !== 1'b1 || d !== 32'd0) begin miscompares++;
      $display("FAIL lw_unmapped: got lat=%0d fault=%0d rdata=%h expected 0 1 00000000", l, f, d); end
    xact(0, 32'h2, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (f !== 1'b1 || d !== 32'd0) begin miscompares++;
      $display("FAIL lw_misaligned: got fault=%0d rdata=%h expected 1 00000000", f, d); end
    xact(0, 32'h1000_0000, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (f !== 1'b0 || d !== 32'd0) begin miscompares++;
      $display("FAIL con_status_empty: got fault=%0d rdata=%h expected 0 00000000", f, d); end
  endtask

  task automatic test_console();
    logic r, f; logic [31:0] d; int l;
    logic [7:0] exp_bytes [5];
    exp_bytes = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    a_cready = 0;
    for (int i = 0; i < 4; i++) begin
      xact(0, 32'h1000_0000, {24'h0, exp_bytes[i]}, 4'b0001, 4'b0000, r, d, f, l);
      vectors++; if (l !== 0 || f !== 1'b0) begin miscompares++;
        $display("FAIL con_push%0d: got lat=%0d fault=%0d expected 0 0", i, l, f); end
    end
    xact(0, 32'h1000_0000, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (d !== 32'h14) begin miscompares++;
      $display("FAIL con_status_full: got %h expected 00000014", d); end
    a_valid = 1; a_addr = 32'h1000_0000; a_wdata = 32'h65; a_wstrb = 4'b0001; a_rmask = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++; if (a_ready !== 1'b0 || a_cdata !== 8'h61) begin miscompares++;
        $display("FAIL con_stall: got ready=%0d head=%h expected 0 61", a_ready, a_cdata); end
      @(posedge clk); #1;
    end
    a_cready = 1;
    @(negedge clk);
    vectors++; if (a_ready !== 1'b1) begin miscompares++;
      $display("FAIL con_push_on_pop: got %0d expected 1", a_ready); end
    @(posedge clk); #1; a_valid = 0;
    $display("xact u0 console store 65 released by pop");
    for (int i = 0; i < 20 && con_q.size() < 5; i++) @(posedge clk);
    #1;
    vectors++; if (con_q.size() !== 5) begin miscompares++;
      $display("FAIL con_count: got %0d expected 5", con_q.size()); end
    for (int i = 0; i < 5 && i < con_q.size(); i++) begin
      vectors++; if (con_q[i] !== exp_bytes[i]) begin miscompares++;
        $display("FAIL con_order%0d: got %h expected %h", i, con_q[i], exp_bytes[i]); end
    end
  endtask

  task automatic test_reset_abort();
    logic r, f; logic [31:0] d; int l;
    xact(1, 32'h10, 32'h55667788, 4'b1111, 4'b0000, r, d, f, l);
    a_cready = 0;
    xact(0, 32'h1000_0000, 32'h7A, 4'b0001, 4'b0000, r, d, f, l);
    b_valid = 1; b_addr = 32'h10; b_wdata = 32'hCAFEF00D; b_wstrb = 4'b1111; b_rmask = 4'b0000;
    @(negedge clk);
    vectors++; if (b_ready !== 1'b0 || a_cvalid !== 1'b1) begin miscompares++;
      $display("FAIL abort_pre: got ready=%0d cvalid=%0d expected 0 1", b_ready, a_cvalid); end
    @(posedge clk); #1; reset = 1;
    @(negedge clk);
    vectors++; if (b_ready !== 1'b0) begin miscompares++;
      $display("FAIL abort_in_reset: got %0d expected 0", b_ready); end
    @(posedge clk); #1; reset = 0; b_valid = 0;
    @(negedge clk);
    vectors++; if ({b_ready, b_fault, a_cvalid} !== 3'b0 || b_rdata !== 32'd0) begin miscompares++;
      $display("FAIL abort_post: got flags=%b rdata=%h expected 000 00000000", {b_ready, b_fault, a_cvalid}, b_rdata); end
    @(posedge clk); #1;
    xact(1, 32'h10, 32'h0, 4'b0000, 4'b1111, r, d, f, l);
    vectors++; if (d !== 32'h55667788) begin miscompares++;
      $display("FAIL abort_no_write: got %h expected 55667788", d); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_wait_states();
    test_unmapped();
    test_console();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/minrv32_dmem_responder.md
Name: minrv32_dmem_responder

Overview:
Memory-side responder for the minrv32 data port. It services mem_valid load and store requests against a local word-organised RAM and one console MMIO region, with configurable wait states. It owns byte-lane steering: the core presents write data and read masks right-justified at lane 0, and the responder aligns them using mem_addr[1:0]. It also flags misaligned and unmapped accesses on a fault output.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words; RAM decodes addresses BASE_ADDR .. BASE_ADDR+4*MEM_WORDS-1.
BASE_ADDR, 32'h0000_0000, RAM base address; must be word aligned.
WAIT_STATES, 0, extra cycles before mem_ready; range 0..15.
CONSOLE_ADDR, 32'h1000_0000, word address of the console data/status register.
FIFO_DEPTH, 4, console TX FIFO entries; must be a power of 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
mem_valid  input  1  request present; request fields held stable until mem_ready.
mem_instr  input  1  instruction-fetch tag; ignored, treated as a data access.
mem_addr  input  32  byte address.
mem_wdata  input  32  right-justified store data.
mem_wstrb  input  4  store size mask: 0001, 0011 or 1111; 0000 means a load.
mem_rmask  input  4  load size mask: 0001, 0011 or 1111.
mem_ready  output  1  request completes this cycle.
mem_rdata  output  32  right-justified load data; valid only while mem_ready is high.
fault  output  1  completing request was misaligned or unmapped; valid only with mem_ready.
console_valid  output  1  FIFO head byte available.
console_data  output  8  FIFO head byte.
console_ready  input  1  sink accepts the head byte when both valid and ready are high.

Behaviour:
- Reset values: state=IDLE, wait counter=0, mem_ready=0, fault=0, mem_rdata=0, console_valid=0, FIFO empty. RAM contents are not reset.
- FSM IDLE:
  - mem_valid with WAIT_STATES=0 completes combinationally in the same cycle. Stores commit on the edge ending that cycle.
  - mem_valid with WAIT_STATES>0 moves to WAIT with counter=WAIT_STATES-1.
- FSM WAIT:
  - Counter decrements each cycle.
  - At counter=0, mem_ready is asserted that cycle and the FSM returns to IDLE at the next edge.
  - A new request may be presented in the cycle after completion.
- mem_valid dropping during WAIT is a protocol violation. Required handling: return to IDLE, no write, no ready.
- Lane alignment, with off=mem_addr[1:0]:
  - Stores write byte lanes (size mask << off), with data mem_wdata << 8*off.
  - Loads return RAM word >> 8*off, zero-filled above the size mask. Sign extension is done by the core.
- Misaligned accesses fault: halfword with off[0]=1, or word with off!=0.
- Unmapped addresses fault: neither the RAM range nor CONSOLE_ADDR (word match, addr[31:2]).
- Any faulting request:
  - completes with normal latency, with mem_ready=1, fault=1, mem_rdata=0;
  - produces no RAM write and no FIFO push.
- Console store:
  - Size is ignored; lane-0 byte mem_wdata[7:0] is pushed.
  - If the FIFO is full, mem_ready is withheld (extra stall) until an entry is popped.
  - Pop and push in the same cycle while full is accepted; count is unchanged.
- Console load returns {24'b0, 3'b0, full, count[3:0]} with count in 0..FIFO_DEPTH. No side effect.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo FIFO_DEPTH.
  - console_valid = (count != 0).
  - Pop when console_valid && console_ready.
  - Count saturates neither way; overflow and underflow are impossible by construction.
- reset asserted mid-WAIT or mid-stall aborts the request with no write, clears the FIFO and returns to IDLE the next cycle.
- A request with both mem_wstrb and mem_rmask nonzero is treated as a store.

Test Plan:
- WAIT_STATES=0: SW 0xDEADBEEF at addr 0x8, then LW 0x8 → ready same cycle each; rdata=0xDEADBEEF, fault=0.
- SB wdata=0x000000AA at 0xA, then LW 0x8 → 0xDEAABEEF. LH with rmask=0011 at 0xA → rdata=0x0000DEAA.
- WAIT_STATES=3: LW at 0x8 → mem_ready exactly 3 cycles after mem_valid rises, one-cycle pulse. SH at 0x9 → fault=1, memory unchanged.
- LW at BASE_ADDR+4*MEM_WORDS → fault=1, rdata=0. LW at CONSOLE_ADDR with empty FIFO → rdata=0.
- console_ready=0, five SB writes 'a'..'e' to CONSOLE_ADDR → first four complete; fifth stalls and status read would give 0x14. Raise console_ready → 'a' pops, fifth completes, bytes emerge a,b,c,d,e in order.
- Assert reset during the WAIT of a SW to 0x10 → no mem_ready and word 0x10 unchanged. Outputs return to reset values one cycle later.
